// File: rtl/div64s_iter.sv
// Sequential signed divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, radix-2 restoring.
// Fixed latency of WIDTH+2 cycles from accept to out_valid, valid/ready on both sides.
module div64s_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [2*WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0]   divisor_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [WIDTH-1:0]   quotient_o,
    output logic [WIDTH-1:0]   remainder_o,
    output logic               overflow_o,
    output logic               div_by_zero_o
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MinMag = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StPrep, StIter, StFix, StDone} state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [WIDTH-1:0]     dmag_q, dmag_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     shreg_q, shreg_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 pre_ovf_q, pre_ovf_d;
    logic                 dbz_q, dbz_d;
    logic [WIDTH-1:0]     quot_q, quot_d;
    logic [WIDTH-1:0]     remo_q, remo_d;
    logic                 ovf_q, ovf_d;
    logic                 dbz_out_q, dbz_out_d;

    logic [2*WIDTH-1:0]   dvd_mag;
    logic [WIDTH-1:0]     dvs_mag;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       trial;
    logic                 qbit;
    logic                 qneg;
    logic                 rneg;
    logic [WIDTH-1:0]     q_signed;
    logic [WIDTH-1:0]     r_signed;
    logic                 fix_ovf;

    always_comb begin
        dvd_mag  = dvd_q[2*WIDTH-1] ? -dvd_q : dvd_q;
        dvs_mag  = dvs_q[WIDTH-1] ? -dvs_q : dvs_q;
        rem_sh   = {rem_q, shreg_q[WIDTH-1]};
        // A set carry-out bit in rem_sh means it already exceeds any WIDTH-bit divisor.
        trial    = {1'b0, rem_sh[WIDTH-1:0]} - {1'b0, dmag_q};
        qbit     = rem_sh[WIDTH] | ~trial[WIDTH];
        qneg     = dvd_q[2*WIDTH-1] ^ dvs_q[WIDTH-1];
        rneg     = dvd_q[2*WIDTH-1];
        q_signed = qneg ? -shreg_q : shreg_q;
        r_signed = rneg ? -rem_q : rem_q;
        fix_ovf  = pre_ovf_q | (~qneg & shreg_q[WIDTH-1]) | (qneg & (shreg_q > MinMag));
    end

    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        dmag_d    = dmag_q;
        rem_d     = rem_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        pre_ovf_d = pre_ovf_q;
        dbz_d     = dbz_q;
        quot_d    = quot_q;
        remo_d    = remo_q;
        ovf_d     = ovf_q;
        dbz_out_d = dbz_out_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    dvd_d   = dividend_i;
                    dvs_d   = divisor_i;
                    state_d = StPrep;
                end
            end
            StPrep: begin
                dmag_d    = dvs_mag;
                dbz_d     = (dvs_q == '0);
                pre_ovf_d = (dvd_mag[2*WIDTH-1:WIDTH] >= dvs_mag);
                rem_d     = dvd_mag[2*WIDTH-1:WIDTH];
                shreg_d   = dvd_mag[WIDTH-1:0];
                cnt_d     = '0;
                state_d   = StIter;
            end
            StIter: begin
                rem_d   = qbit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                shreg_d = {shreg_q[WIDTH-2:0], qbit};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (dbz_q) begin
                    quot_d    = '0;
                    remo_d    = '0;
                    ovf_d     = 1'b0;
                    dbz_out_d = 1'b1;
                end else if (fix_ovf) begin
                    quot_d    = '0;
                    remo_d    = '0;
                    ovf_d     = 1'b1;
                    dbz_out_d = 1'b0;
                end else begin
                    quot_d    = q_signed;
                    remo_d    = r_signed;
                    ovf_d     = 1'b0;
                    dbz_out_d = 1'b0;
                end
                state_d = StDone;
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            dvd_q     <= '0;
            dvs_q     <= '0;
            dmag_q    <= '0;
            rem_q     <= '0;
            shreg_q   <= '0;
            cnt_q     <= '0;
            pre_ovf_q <= 1'b0;
            dbz_q     <= 1'b0;
            quot_q    <= '0;
            remo_q    <= '0;
            ovf_q     <= 1'b0;
            dbz_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            dmag_q    <= dmag_d;
            rem_q     <= rem_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            pre_ovf_q <= pre_ovf_d;
            dbz_q     <= dbz_d;
            quot_q    <= quot_d;
            remo_q    <= remo_d;
            ovf_q     <= ovf_d;
            dbz_out_q <= dbz_out_d;
        end
    end

    assign in_ready_o    = (state_q == StIdle);
    assign out_valid_o   = (state_q == StDone);
    assign quotient_o    = quot_q;
    assign remainder_o   = remo_q;
    assign overflow_o    = ovf_q;
    assign div_by_zero_o = dbz_out_q;

endmodule

// File: tb/tb_div64s_iter.sv
// Bench for div64s_iter: directed corner cases, backpressure, mid-op reset and random
// operands checked against a wide-integer reference model.
module tb_div64s_iter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        overflow;
    logic        div_by_zero;

    int tests = 0;
    int fails = 0;

    div64s_iter #(.WIDTH(32)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .dividend_i   (dividend),
        .divisor_i    (divisor),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .quotient_o   (quotient),
        .remainder_o  (remainder),
        .overflow_o   (overflow),
        .div_by_zero_o(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, fails so far %0d", fails);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Exact signed arithmetic on 128 bits, then apply the result-representability rules.
    task automatic model(input logic [63:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic ov, output logic dz);
        logic signed [127:0] sa, sb, sq, sr;
        sa = {{64{a[63]}}, a};
        sb = {{96{b[31]}}, b};
        q = '0; r = '0; ov = 1'b0; dz = 1'b0;
        if (b == 32'd0) begin
            dz = 1'b1;
        end else begin
            sq = sa / sb;
            sr = sa % sb;
            ov = (sq > 128'sd2147483647) || (sq < -128'sd2147483648);
            if (!ov) begin
                q = sq[31:0];
                r = sr[31:0];
            end
        end
    endtask

    task automatic start_op(input logic [63:0] a, input logic [31:0] b);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic [63:0] a, input logic [31:0] b);
        logic [31:0] eq, er;
        logic        eov, edz;
        int          lat;
        model(a, b, eq, er, eov, edz);
        start_op(a, b);
        wait_done(lat);
        chk({tag, " latency"}, 64'(lat), 64'd34);
        chk({tag, " quotient"}, 64'(quotient), 64'(eq));
        chk({tag, " remainder"}, 64'(remainder), 64'(er));
        chk({tag, " overflow"}, 64'(overflow), 64'(eov));
        chk({tag, " div_by_zero"}, 64'(div_by_zero), 64'(edz));
        release_out();
    endtask

    typedef struct {
        logic [63:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        ov;
        logic        dz;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int          lat;
        logic [31:0] x, y;
        logic signed [63:0] sa;
        logic signed [31:0] sb;

        vecs[0] = '{64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0};
        vecs[1] = '{-64'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[2] = '{64'h3FFF_FFFF_0000_0001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b0};
        vecs[3] = '{64'h4000_0000_0000_0000, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b0, 1'b0};
        vecs[4] = '{64'h4000_0000_0000_0000, 32'h4000_0000, 32'd0, 32'd0, 1'b1, 1'b0};
        vecs[5] = '{64'h2000_0000_0000_0000, 32'h4000_0000, 32'd0, 32'd0, 1'b1, 1'b0};
        vecs[6] = '{64'd12345, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1};
        vecs[7] = '{64'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0};
        vecs[8] = '{-64'sd7, -32'sd2, 32'd3, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[9] = '{64'h8000_0000_0000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #22;
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset quotient", 64'(quotient), 64'd0);
        chk("reset remainder", 64'(remainder), 64'd0);
        chk("reset overflow", 64'(overflow), 64'd0);
        chk("reset div_by_zero", 64'(div_by_zero), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            wait_done(lat);
            chk($sformatf("dir%0d latency", i), 64'(lat), 64'd34);
            chk($sformatf("dir%0d quotient", i), 64'(quotient), 64'(vecs[i].q));
            chk($sformatf("dir%0d remainder", i), 64'(remainder), 64'(vecs[i].r));
            chk($sformatf("dir%0d overflow", i), 64'(overflow), 64'(vecs[i].ov));
            chk($sformatf("dir%0d div_by_zero", i), 64'(div_by_zero), 64'(vecs[i].dz));
            release_out();
            chk($sformatf("dir%0d in_ready after handshake", i), 64'(in_ready), 64'd1);
            chk($sformatf("dir%0d out_valid dropped", i), 64'(out_valid), 64'd0);
        end

        // Backpressure: result held, new operands ignored.
        start_op(-64'sd100, 32'd7);
        wait_done(lat);
        chk("bp latency", 64'(lat), 64'd34);
        dividend = 64'd1;
        divisor  = 32'd1;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d out_valid", k), 64'(out_valid), 64'd1);
            chk($sformatf("bp%0d in_ready", k), 64'(in_ready), 64'd0);
            chk($sformatf("bp%0d quotient", k), 64'(quotient), 64'hFFFF_FFF2);
            chk($sformatf("bp%0d remainder", k), 64'(remainder), 64'hFFFF_FFFE);
        end
        in_valid = 1'b0;
        release_out();
        chk("bp in_ready after release", 64'(in_ready), 64'd1);
        chk("bp out_valid after release", 64'(out_valid), 64'd0);
        chk("bp quotient held in idle", 64'(quotient), 64'hFFFF_FFF2);

        // Reset in the middle of the iteration phase.
        run_check("pre-reset", 64'd100, 32'd7);
        start_op(64'd999, 32'd5);
        repeat (10) @(posedge clk);
        #1;
        chk("midop busy", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst quotient", 64'(quotient), 64'd0);
        chk("midrst remainder", 64'(remainder), 64'd0);
        chk("midrst in_ready", 64'(in_ready), 64'd1);
        chk("midrst out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_check("post-reset", 64'd100, 32'd7);
        chk("post-reset quotient const", 64'(quotient), 64'd14);

        // Round trip: product of two factors divided by one factor returns the other.
        for (int i = 0; i < 16; i++) begin
            x = $urandom;
            y = $urandom;
            if (i == 0) begin
                x = 32'h8000_0000;
                y = 32'hFFFF_FFFF;
            end
            if (y == 32'd0) y = 32'd1;
            sa = longint'(int'(x)) * longint'(int'(y));
            run_check($sformatf("rt%0d", i), sa, y);
            chk($sformatf("rt%0d factor", i), 64'(quotient), 64'(x));
            chk($sformatf("rt%0d zero rem", i), 64'(remainder), 64'd0);
        end

        // General operands of varied magnitude, including overflow and zero divisor.
        for (int i = 0; i < 16; i++) begin
            sa = {$urandom, $urandom};
            sa = sa >>> $urandom_range(0, 50);
            sb = $urandom;
            if (i % 3 == 0) sb = sb >>> $urandom_range(0, 30);
            if (i == 5) sb = '0;
            run_check($sformatf("gen%0d", i), sa, sb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
